// File: rtl/ahb_resp_mux.sv
// Purpose : AHB-Lite data-phase response mux with a built-in default slave.
// Latency : zero added latency; SLAVE-phase outputs follow slave inputs combinationally.
// Backpr. : hready follows readyout[sel]; default-slave ERROR stalls one cycle (ERR1).
//
// Ports: clk/rst (sync active-high), hsel_s/htrans (address phase),
//        rdata/resp/readyout (per-slave data phase), hrdata/hresp/hready (to master),
//        timeout (one-cycle pulse when a stalled slave is aborted).
// Optional feature macro: AHB_RESP_MUX_TIMEOUT_EN (stall timeout, limit TIMEOUT_CYCLES).
module ahb_resp_mux #(
    parameter int N_SLAVES       = 2,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SLAVES-1:0]          hsel_s,
    input  logic [1:0]                   htrans,
    input  logic [N_SLAVES*DATA_W-1:0]   rdata,
    input  logic [N_SLAVES-1:0]          resp,
    input  logic [N_SLAVES-1:0]          readyout,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hresp,
    output logic                         hready,
    output logic                         timeout
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLAVE = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel, sel_nxt;
    logic [4:0]         hit_cnt;
    logic [SEL_W-1:0]   hit_idx;
    logic               xfer_req;
    logic               to_fire;

    // NONSEQ or SEQ; written over both bits so the whole bus is consumed.
    assign xfer_req = (htrans == 2'b10) || (htrans == 2'b11);

    // Count asserted selects and remember the (last) hit index; only a
    // count of exactly one is a legal decode.
    always_comb begin
        hit_cnt = '0;
        hit_idx = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (hsel_s[i]) begin
                hit_cnt = hit_cnt + 5'd1;
                hit_idx = SEL_W'(i);
            end
        end
    end

`ifdef AHB_RESP_MUX_TIMEOUT_EN
    logic [15:0] stall_cnt;
`endif

    always_comb begin
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        state_nxt = state;
        sel_nxt   = sel;
        to_fire   = 1'b0;

        case (state)
            ST_SLAVE: begin
                hready = readyout[sel];
                hresp  = resp[sel];
                hrdata = rdata[sel*DATA_W +: DATA_W];
            end
            ST_ERR1: begin
                hready    = 1'b0;
                hresp     = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = 1'b1;
            end
            default: ;
        endcase

        // Any cycle with hready high completes the current data phase and
        // accepts the next address phase on the same edge.
        if (hready) begin
            if (!xfer_req) begin
                state_nxt = ST_IDLE;
            end else if (hit_cnt == 5'd1) begin
                state_nxt = ST_SLAVE;
                sel_nxt   = hit_idx;
            end else begin
                state_nxt = ST_ERR1;
            end
        end

`ifdef AHB_RESP_MUX_TIMEOUT_EN
        // This is the TIMEOUT_CYCLES-th consecutive stalled cycle: abort.
        if (state == ST_SLAVE && !readyout[sel] &&
            stall_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = ST_ERR1;
            to_fire   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

`ifdef AHB_RESP_MUX_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_fire;
            // Entry to SLAVE includes a back-to-back SLAVE->SLAVE handoff.
            if (state_nxt == ST_SLAVE && (state != ST_SLAVE || hready)) begin
                stall_cnt <= '0;
            end else if (state == ST_SLAVE && !readyout[sel]) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
module tb_ahb_resp_mux;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   hsel_s;
    logic [1:0]      htrans;
    logic [NS*DW-1:0] rdata;
    logic [NS-1:0]   resp;
    logic [NS-1:0]   readyout;
    logic [DW-1:0]   hrdata;
    logic            hresp;
    logic            hready;
    logic            timeout;

    int n_checks = 0;
    int n_pass   = 0;

    ahb_resp_mux #(.N_SLAVES(NS), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .hsel_s   (hsel_s),
        .htrans   (htrans),
        .rdata    (rdata),
        .resp     (resp),
        .readyout (readyout),
        .hrdata   (hrdata),
        .hresp    (hresp),
        .hready   (hready),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Reference model: the outstanding data phase described as a transaction.
    // phase: 0 none, 1 slave transfer, 2 error first cycle, 3 error final cycle
    int m_phase  = 0;
    int m_idx    = 0;
    int m_stalls = 0;
    bit m_to     = 1'b0;

    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;

    task automatic model_outputs();
        e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
        if (m_phase == 1) begin
            e_rdy  = readyout[m_idx];
            e_resp = resp[m_idx];
            e_data = rdata[m_idx*DW +: DW];
        end else if (m_phase == 2) begin
            e_rdy = 1'b0; e_resp = 1'b1;
        end else if (m_phase == 3) begin
            e_resp = 1'b1;
        end
    endtask

    task automatic model_edge();
        int ones;
        model_outputs();
        if (rst) begin
            m_phase = 0; m_stalls = 0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_phase == 2) begin
            m_phase = 3;
        end else if (e_rdy) begin
            ones = $countones(hsel_s);
            if (htrans < 2) begin
                m_phase = 0;
            end else if (ones == 1) begin
                m_phase = 1; m_stalls = 0;
                for (int i = 0; i < NS; i++) if (hsel_s[i]) m_idx = i;
            end else begin
                m_phase = 2;
            end
        end else begin
            m_stalls++;
            if (TO_EN && m_stalls == TO) begin
                m_phase = 2; m_to = 1'b1;
            end
        end
    endtask

    // Called just after a rising edge: apply inputs, check mid-cycle, advance.
    task automatic tick(input logic r, input logic [1:0] tr, input logic [NS-1:0] hs,
                        input logic [NS-1:0] ro, input logic [NS-1:0] rs);
        rst = r; htrans = tr; hsel_s = hs; readyout = ro; resp = rs;
        @(negedge clk);
        model_outputs();
        check("hready",  {31'd0, hready},  {31'd0, e_rdy});
        check("hresp",   {31'd0, hresp},   {31'd0, e_resp});
        check("hrdata",  hrdata,           e_data);
        check("timeout", {31'd0, timeout}, {31'd0, m_to});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1; htrans = 2'b00; hsel_s = '0; readyout = '1; resp = '0;
        for (int i = 0; i < NS; i++) rdata[i*DW +: DW] = $urandom;
        rdata[1*DW +: DW] = 32'hDEADBEEF;
        @(posedge clk); @(posedge clk); #1;
        m_phase = 0; m_stalls = 0; m_to = 1'b0;

        // Reset state and hold reset one more cycle.
        tick(1'b1, 2'b10, 4'b0010, 4'b1111, 4'b0000);
        check("rst_hready", {31'd0, hready}, 32'd1);

        // Single transfer to slave 1 with DEADBEEF data.
        tick(1'b0, 2'b10, 4'b0010, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        // Unselected NONSEQ -> default-slave error, then idle.
        tick(1'b0, 2'b10, 4'b0000, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        // Slave 0 stalls 3 cycles while the next address (slave 1) waits.
        tick(1'b0, 2'b10, 4'b0001, 4'b1111, 4'b0000);
        for (int k = 0; k < 3; k++) tick(1'b0, 2'b10, 4'b0010, 4'b1110, 4'b0000);
        tick(1'b0, 2'b11, 4'b0010, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        // Multi-hot select -> error sequence.
        tick(1'b0, 2'b10, 4'b0101, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        // Reset during ERR1 overrides the error sequence.
        tick(1'b0, 2'b10, 4'b0000, 4'b1111, 4'b0000);
        tick(1'b1, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        // Slave two-cycle ERROR passes through unchanged.
        tick(1'b0, 2'b10, 4'b0100, 4'b1111, 4'b0000);
        tick(1'b0, 2'b00, 4'b0000, 4'b1011, 4'b0100);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0100);
        tick(1'b0, 2'b00, 4'b0000, 4'b1111, 4'b0000);
        // Long stall: timeout abort when enabled, endless wait otherwise.
        tick(1'b0, 2'b10, 4'b1000, 4'b1111, 4'b0000);
        for (int k = 0; k < 8; k++) tick(1'b0, 2'b00, 4'b0000, 4'b0111, 4'b0000);
        tick(1'b1, 2'b00, 4'b0000, 4'b1111, 4'b0000);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [NS-1:0] hs;
            logic [NS-1:0] ro;
            for (int i = 0; i < NS; i++) rdata[i*DW +: DW] = $urandom;
            if ($urandom_range(0, 9) < 7) hs = NS'(1 << $urandom_range(0, NS-1));
            else hs = NS'($urandom);
            for (int i = 0; i < NS; i++) ro[i] = ($urandom_range(0, 9) < 7);
            tick(($urandom_range(0, 59) == 0), 2'($urandom), hs, ro, NS'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
